rsa_seq_core: RTL and testbench

- Sequential, parametrised successor to the combinational RSA key IP.
- Accepts P, Q and E, then computes N = P*Q and D = E^-1 mod phi, with phi = (P-1)(Q-1).
- Uses an iterative extended-Euclid FSM, so there is no fixed unroll depth and it works at any WIDTH.
- Optionally encrypts one message as C = M^E mod N by square-and-multiply. Flags non-invertible keys.
- Sits between the key-load interface and the crypto datapath.

---
 rtl/rsa_pkg.sv | 33 +++
 rtl/rsa_seq_core_modmul.sv | 24 ++
 rtl/rsa_seq_core.sv | 183 ++++++++++++++++++
 tb/tb_rsa_seq_core.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared types and width helpers for the sequential RSA key core.
package rsa_pkg;

    // Controller states, in the order a run visits them.
    typedef enum logic [2:0] {
        IDLE,
        PREP,
        EUC,
        FIX,
        EXP,
        DONE
    } state_t;

    // N, phi, E, D, M and C are all twice the prime width.
    function automatic int dw(input int w);
        return 2 * w;
    endfunction

    // Width of a raw modular product before reduction.
    function automatic int qw(input int w);
        return 4 * w;
    endfunction

    // Upper bound on extended-Euclid iterations for WIDTH-bit primes.
    // The extra steps cover the leading swap when E > phi.
    localparam int EUC_STEP_MUL = 3;
    localparam int EUC_STEP_ADD = 2;

    function automatic int euc_bound(input int w);
        return EUC_STEP_MUL * w + EUC_STEP_ADD;
    endfunction

endpackage

// File: rtl/rsa_seq_core_modmul.sv
// Combinational (a*b) mod n at 2*WIDTH bits; n == 0 yields 0.
module rsa_modmul
    import rsa_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [dw(WIDTH)-1:0] a,
    input  logic [dw(WIDTH)-1:0] b,
    input  logic [dw(WIDTH)-1:0] n,
    output logic [dw(WIDTH)-1:0] r
);
    localparam int W2 = dw(WIDTH);
    localparam int W4 = qw(WIDTH);

    logic [W4-1:0] prod;

    // Full-width product, then reduce; a zero modulus never reaches a divider.
    always_comb begin
        prod = W4'(a) * W4'(b);
        r    = '0;
        if (n != '0) r = W2'(prod % W4'(n));
    end

endmodule

// File: rtl/rsa_seq_core.sv
// Sequential RSA key core: N = P*Q, D = E^-1 mod phi via iterative
// extended Euclid, optional C = M^E mod N by left-to-right square-and-multiply.
module rsa_seq_core
    import rsa_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      in_p,
    input  logic [WIDTH-1:0]      in_q,
    input  logic [dw(WIDTH)-1:0]  in_e,
    input  logic [dw(WIDTH)-1:0]  in_m,
    input  logic                  in_mode,
    output logic                  busy,
    output logic                  out_valid,
    output logic [dw(WIDTH)-1:0]  out_n,
    output logic [dw(WIDTH)-1:0]  out_d,
    output logic [dw(WIDTH)-1:0]  out_c,
    output logic                  out_err
);
    localparam int W2 = dw(WIDTH);
    localparam int TW = W2 + 1;                      // signed Bezout coefficient width
    localparam int CW = (W2 > 1) ? $clog2(W2) : 1;   // exponent bit index

    state_t state, state_nx;

    logic [WIDTH-1:0] p_reg, q_reg;
    logic [W2-1:0]    e_reg, m_reg;
    logic             mode_reg;
    logic [W2-1:0]    n_reg, phi;
    logic [W2-1:0]    r0, r1;
    logic [TW-1:0]    t0, t1;
    logic [W2-1:0]    acc, mr;
    logic [CW-1:0]    cnt;
    logic [W2-1:0]    d_reg;
    logic             err_reg;

    logic [W2-1:0]    n_prep, phi_prep;
    logic [W2-1:0]    q_div, rem;
    logic [TW-1:0]    t_nx, t_adj;
    logic             err_fix;
    logic [W2-1:0]    d_fix, mr_init;
    logic [W2-1:0]    sq, ml, acc_nx;
    logic [W2-1:0]    d_out, c_out;
    logic             err_out;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state decode and status outputs.
    always_comb begin
        state_nx  = state;
        busy      = (state != IDLE);
        out_valid = (state == DONE);
        case (state)
            IDLE: if (in_valid) state_nx = PREP;
            PREP: state_nx = EUC;
            EUC:  if (r1 == '0) state_nx = FIX;
            FIX:  state_nx = (mode_reg && !err_fix) ? EXP : DONE;
            EXP:  if (cnt == '0) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Modulus and totient from the latched primes.
    always_comb begin
        n_prep   = W2'(p_reg) * W2'(q_reg);
        phi_prep = n_prep - W2'(p_reg) - W2'(q_reg) + W2'(1);
    end

    // One Euclid step; the divider is fenced off when r1 is zero.
    always_comb begin
        q_div = '0;
        rem   = '0;
        if (r1 != '0) begin
            q_div = r0 / r1;
            rem   = r0 % r1;
        end
        // Two's-complement wrap is exact: the true result always fits TW bits.
        t_nx = t0 - TW'(t1 * TW'(q_div));
    end

    // Fold the final coefficient into [0, phi) and decide invertibility.
    always_comb begin
        err_fix = (r0 != W2'(1)) || (n_reg == '0);
        t_adj   = t0[TW-1] ? (t0 + TW'(phi)) : t0;
        d_fix   = '0;
        // t_adj >= phi only arises for phi <= 1, where D must be 0.
        if (!err_fix && (t_adj < TW'(phi))) d_fix = t_adj[W2-1:0];
        mr_init = (n_reg != '0) ? (m_reg % n_reg) : '0;
    end

    rsa_modmul #(.WIDTH(WIDTH)) u_sq (.a(acc), .b(acc), .n(n_reg), .r(sq));
    rsa_modmul #(.WIDTH(WIDTH)) u_ml (.a(sq),  .b(mr),  .n(n_reg), .r(ml));

    // Square always, multiply in when the current exponent bit is set.
    always_comb begin
        acc_nx  = e_reg[cnt] ? ml : sq;
        d_out   = (state == FIX) ? d_fix   : d_reg;
        err_out = (state == FIX) ? err_fix : err_reg;
        c_out   = (state == EXP) ? acc_nx  : '0;
    end

    // Operand latch and Euclid / exponentiation datapath.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_reg    <= '0;
            q_reg    <= '0;
            e_reg    <= '0;
            m_reg    <= '0;
            mode_reg <= 1'b0;
            n_reg    <= '0;
            phi      <= '0;
            r0       <= '0;
            r1       <= '0;
            t0       <= '0;
            t1       <= '0;
            acc      <= '0;
            mr       <= '0;
            cnt      <= '0;
            d_reg    <= '0;
            err_reg  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    p_reg    <= in_p;
                    q_reg    <= in_q;
                    e_reg    <= in_e;
                    m_reg    <= in_m;
                    mode_reg <= in_mode;
                end
                PREP: begin
                    n_reg <= n_prep;
                    phi   <= phi_prep;
                    r0    <= phi_prep;
                    r1    <= e_reg;
                    t0    <= '0;
                    t1    <= TW'(1);
                end
                EUC: if (r1 != '0) begin
                    r0 <= r1;
                    r1 <= rem;
                    t0 <= t1;
                    t1 <= t_nx;
                end
                FIX: begin
                    d_reg   <= d_fix;
                    err_reg <= err_fix;
                    acc     <= (n_reg == W2'(1)) ? '0 : W2'(1);
                    mr      <= mr_init;
                    cnt     <= CW'(W2 - 1);
                end
                EXP: begin
                    acc <= acc_nx;
                    cnt <= cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Result registers load on entry to DONE and hold until the next one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_n   <= '0;
            out_d   <= '0;
            out_c   <= '0;
            out_err <= 1'b0;
        end else if (state_nx == DONE) begin
            out_n   <= n_reg;
            out_d   <= d_out;
            out_c   <= c_out;
            out_err <= err_out;
        end
    end

endmodule

// File: tb/tb_rsa_seq_core.sv
// Scoreboard bench: directed WIDTH=4 vectors plus a WIDTH=8 modelled sweep.
module tb_rsa_seq_core;
    import rsa_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       iv4 = 1'b0, md4 = 1'b0;
    logic [3:0] p4 = '0, q4 = '0;
    logic [7:0] e4 = '0, m4 = '0;
    logic       busy4, ov4, err4;
    logic [7:0] n4o, d4o, c4o;

    logic        iv8 = 1'b0, md8 = 1'b0;
    logic [7:0]  p8 = '0, q8 = '0;
    logic [15:0] e8 = '0, m8 = '0;
    logic        busy8, ov8, err8;
    logic [15:0] n8o, d8o, c8o;

    rsa_seq_core #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_p(p4), .in_q(q4),
        .in_e(e4), .in_m(m4), .in_mode(md4), .busy(busy4), .out_valid(ov4),
        .out_n(n4o), .out_d(d4o), .out_c(c4o), .out_err(err4)
    );

    rsa_seq_core #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_p(p8), .in_q(q8),
        .in_e(e8), .in_m(m8), .in_mode(md8), .busy(busy8), .out_valid(ov8),
        .out_n(n8o), .out_d(d8o), .out_c(c8o), .out_err(err8)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint n, d, c;
        logic   err;
        int     lat;     // exact latency, or -1 to check only the bound
        int     maxlat;
        int     t0;
    } exp_t;

    exp_t sb4[$], sb8[$];
    exp_t x4, x8;
    int total = 0, bad = 0, cyc = 0;

    int primes[$] = '{2,3,5,7,11,13,17,19,23,29,31,37,41,43,47,53,59,61,67,71,
                      73,79,83,89,97,101,103,107,109,113,127,131,137,139,149,
                      151,157,163,167,173,179,181,191,193,197,199,211,223,227,
                      229,233,239,241,251};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, req);
        end
    endtask

    task automatic chk_lat(input string nm, input int lat, input exp_t x);
        if (x.lat >= 0) chk(nm, 64'(lat), 64'(x.lat));
        else begin
            total++;
            if (lat > x.maxlat || lat < 3) begin
                bad++;
                $display("FAIL %s: got %0d want <= %0d", nm, lat, x.maxlat);
            end
        end
    endtask

    // Monitors: pop one expectation per out_valid pulse.
    always @(negedge clk) begin
        if (rst_n && ov4) begin
            if (sb4.size() == 0) begin
                total++; bad++;
                $display("FAIL w4 extra out_valid: got 1 want 0");
            end else begin
                x4 = sb4.pop_front();
                chk("w4 n",   64'(n4o),  64'(x4.n));
                chk("w4 d",   64'(d4o),  64'(x4.d));
                chk("w4 c",   64'(c4o),  64'(x4.c));
                chk("w4 err", 64'(err4), 64'(x4.err));
                chk_lat("w4 latency", cyc - x4.t0, x4);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && ov8) begin
            if (sb8.size() == 0) begin
                total++; bad++;
                $display("FAIL w8 extra out_valid: got 1 want 0");
            end else begin
                x8 = sb8.pop_front();
                chk("w8 n",   64'(n8o),  64'(x8.n));
                chk("w8 d",   64'(d8o),  64'(x8.d));
                chk("w8 c",   64'(c8o),  64'(x8.c));
                chk("w8 err", 64'(err8), 64'(x8.err));
                chk_lat("w8 latency", cyc - x8.t0, x8);
            end
        end
    end

    function automatic longint gcd(input longint a, input longint b);
        longint t;
        while (b != 0) begin t = a % b; a = b; b = t; end
        return a;
    endfunction

    // Brute-force inverse: independent of any Euclid formulation.
    function automatic longint inv_brute(input longint e, input longint phi);
        for (longint d = 0; d < phi; d++)
            if (((d * e) % phi) == (1 % phi)) return d;
        return 0;
    endfunction

    // Right-to-left binary exponentiation.
    function automatic longint modpow(input longint m, input longint e, input longint n);
        longint r, b;
        if (n == 1) return 0;
        r = 1; b = m % n;
        while (e > 0) begin
            if (e[0]) r = (r * b) % n;
            b = (b * b) % n;
            e = e >> 1;
        end
        return r;
    endfunction

    task automatic load4(input int p, input int q, input int e, input int m, input int md,
                         input longint en, input longint ed, input longint ec,
                         input logic ee, input int lat);
        exp_t x;
        int i;
        i = 0;
        @(negedge clk);
        while (busy4 && i < 500) begin @(negedge clk); i++; end
        if (busy4) begin
            total++; bad++;
            $display("FAIL w4 idle timeout: got busy 1 want 0");
        end
        p4 = 4'(p); q4 = 4'(q); e4 = 8'(e); m4 = 8'(m); md4 = md[0]; iv4 = 1'b1;
        @(posedge clk); #1;
        iv4 = 1'b0;
        x.n = en; x.d = ed; x.c = ec; x.err = ee; x.lat = lat; x.maxlat = 0; x.t0 = cyc;
        sb4.push_back(x);
    endtask

    task automatic load8(input int p, input int q, input int e, input int m, input int md);
        exp_t x;
        longint n, phi;
        int i;
        n   = longint'(p) * q;
        phi = longint'(p - 1) * (q - 1);
        x.err = (gcd(longint'(e), phi) != 1) || (n == 0);
        x.n   = n & 64'hFFFF;
        x.d   = x.err ? 0 : inv_brute(longint'(e), phi);
        x.c   = (md != 0 && !x.err) ? modpow(longint'(m), longint'(e), n) : 0;
        x.lat = -1;
        x.maxlat = 3 + euc_bound(8) + ((md != 0 && !x.err) ? 16 : 0);
        i = 0;
        @(negedge clk);
        while (busy8 && i < 500) begin @(negedge clk); i++; end
        if (busy8) begin
            total++; bad++;
            $display("FAIL w8 idle timeout: got busy 1 want 0");
        end
        p8 = 8'(p); q8 = 8'(q); e8 = 16'(e); m8 = 16'(m); md8 = md[0]; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        x.t0 = cyc;
        sb8.push_back(x);
    endtask

    task automatic drain(input int which);
        int i;
        i = 0;
        while (((which == 4) ? sb4.size() : sb8.size()) != 0 && i < 2000) begin
            @(negedge clk); i++;
        end
        if (((which == 4) ? sb4.size() : sb8.size()) != 0) begin
            total++; bad++;
            $display("FAIL w%0d result timeout: got pending %0d want 0", which,
                     (which == 4) ? sb4.size() : sb8.size());
            if (which == 4) sb4.delete(); else sb8.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int p, q;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy",  64'(busy4), 0);
        chk("reset valid", 64'(ov4),   0);
        chk("reset n",     64'(n4o),   0);
        chk("reset d",     64'(d4o),   0);
        chk("reset c",     64'(c4o),   0);
        chk("reset err",   64'(err4),  0);
        @(negedge clk);
        rst_n = 1'b1;

        // Keygen only.
        load4(5, 11, 3, 0, 0, 55, 27, 0, 1'b0, 5);
        @(negedge clk);
        chk("w4 busy after accept", 64'(busy4), 1);
        drain(4);

        // Keygen plus encrypt: 2^3 mod 55, EXP adds exactly 8 cycles.
        load4(5, 11, 3, 2, 1, 55, 27, 8, 1'b0, 13);
        drain(4);

        // Non-invertible E: EXP skipped.
        load4(5, 7, 6, 9, 1, 35, 0, 0, 1'b1, 4);
        drain(4);

        // E > phi, plus loads while busy that must be ignored.
        load4(7, 5, 29, 0, 0, 35, 5, 0, 1'b0, 8);
        @(negedge clk);
        p4 = 4'd3; q4 = 4'd3; e4 = 8'd5; m4 = 8'd4; md4 = 1'b1; iv4 = 1'b1;
        repeat (3) @(negedge clk);
        iv4 = 1'b0;
        drain(4);

        // Abort mid-Euclid.
        @(negedge clk);
        p4 = 4'd5; q4 = 4'd11; e4 = 8'd3; md4 = 1'b0; iv4 = 1'b1;
        @(posedge clk); #1;
        iv4 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort busy",  64'(busy4), 0);
        chk("abort valid", 64'(ov4),   0);
        chk("abort n",     64'(n4o),   0);
        chk("abort d",     64'(d4o),   0);
        chk("abort c",     64'(c4o),   0);
        chk("abort err",   64'(err4),  0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        load4(3, 11, 7, 0, 0, 33, 3, 0, 1'b0, 6);
        drain(4);

        // WIDTH=8 sweep, back-to-back, against the software model.
        load8(2, 2, 5, 3, 1);
        load8(61, 53, 17, 65, 1);
        for (int i = 0; i < 22; i++) begin
            if (i % 3 == 0) begin
                p = $urandom_range(2, 255);
                q = $urandom_range(2, 255);
            end else begin
                p = primes[$urandom_range(0, primes.size() - 1)];
                q = primes[$urandom_range(0, primes.size() - 1)];
            end
            load8(p, q, int'($urandom_range(1, 65535) | 1), int'($urandom_range(0, 65535)),
                  int'($urandom_range(0, 1)));
        end
        drain(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
